pc_ras: RTL and testbench

Parametrised program counter with an integrated hardware return-address stack (RAS). It supersedes the plain load/increment PC. It adds relative branches, call/return with a configurable-depth LIFO of return addresses, a pipeline stall input, and sticky overflow/underflow error flags. It sits in the fetch stage: it drives the instruction-memory address and takes its next-PC control from the decode/control unit.

---
 rtl/pc_pkg.sv | 23 ++
 rtl/pc_ras_stack.sv | 85 ++++++++
 rtl/pc_ras.sv | 113 +++++++++++
 tb/tb_pc_ras.sv | 166 ++++++++++++++++
 4 files changed

// File: rtl/pc_pkg.sv
// ---------------------------------------------------------------------------
// pc_pkg
// Shared definitions for the program counter with return-address stack.
//   PC_OP_W : width of the next-PC operation code
//   pc_op_e : next-PC operation encodings driven by the decode/control unit
// ---------------------------------------------------------------------------
package pc_pkg;

   localparam int PC_OP_W = 3;

   typedef enum logic [PC_OP_W-1:0] {
      PC_HOLD = 3'd0,  // keep current PC
      PC_INC  = 3'd1,  // PC + 1
      PC_JMP  = 3'd2,  // absolute target from d
      PC_REL  = 3'd3,  // PC + signed offset d
      PC_CALL = 3'd4,  // push PC + 1, jump to d
      PC_RET  = 3'd5   // pop return address into PC
   } pc_op_e;

   // Encodings 6 and 7 are reserved. Decoders fall through to their default
   // branch for them, which behaves exactly like PC_HOLD.

endpackage : pc_pkg

// File: rtl/pc_ras_stack.sv
// ---------------------------------------------------------------------------
// pc_ras_stack
// LIFO of return addresses, indexed by its own occupancy count.
// A push when full or a pop when empty is ignored, so callers may issue
// requests blindly and read the status flags separately.
//   clk   : clock, state updates on rising edge
//   rst   : synchronous active-high reset (clears depth only)
//   push  : write din at stack[depth], depth + 1
//   pop   : depth - 1
//   din   : value to push
//   top   : stack[depth-1], zero when empty
//   depth : number of valid entries
//   full  : depth == RAS_DEPTH
//   empty : depth == 0
// ---------------------------------------------------------------------------
module pc_ras_stack #(
   parameter  int WIDTH     = 16,
   parameter  int RAS_DEPTH = 8,
   localparam int DEPTH_W   = $clog2(RAS_DEPTH + 1)
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               push,
   input  logic               pop,
   input  logic [WIDTH-1:0]   din,
   output logic [WIDTH-1:0]   top,
   output logic [DEPTH_W-1:0] depth,
   output logic               full,
   output logic               empty
);

   logic [WIDTH-1:0]   stack_q [RAS_DEPTH];
   logic [DEPTH_W-1:0] depth_q, depth_d;
   logic               do_push, do_pop;

   assign full    = (depth_q == DEPTH_W'(RAS_DEPTH));
   assign empty   = (depth_q == '0);
   assign do_push = push && !full;
   assign do_pop  = pop && !empty && !push;
   assign depth   = depth_q;

   // NOTE: every variable written in a combinational block gets a default
   // first; a path that leaves it unassigned would infer a latch.
   always_comb begin
      depth_d = depth_q;
      if (do_push) begin
         depth_d = depth_q + DEPTH_W'(1);
      end else if (do_pop) begin
         depth_d = depth_q - DEPTH_W'(1);
      end
   end

   // NOTE: state registers use non-blocking assignments so every flop
   // samples pre-edge values regardless of process ordering.
   always_ff @(posedge clk) begin
      if (rst) begin
         depth_q <= '0;
      end else begin
         depth_q <= depth_d;
      end
   end

   // NOTE: the entry array has no reset; entries at or above depth are
   // don't-care, so clearing them would only add reset fan-out.
   // Index compare loops keep the select width-exact for any RAS_DEPTH.
   always_ff @(posedge clk) begin
      if (!rst && do_push) begin
         for (int i = 0; i < RAS_DEPTH; i++) begin
            if (DEPTH_W'(i) == depth_q) begin
               stack_q[i] <= din;
            end
         end
      end
   end

   always_comb begin
      top = '0;
      for (int i = 0; i < RAS_DEPTH; i++) begin
         if (DEPTH_W'(i + 1) == depth_q) begin
            top = stack_q[i];
         end
      end
   end

endmodule : pc_ras_stack

// File: rtl/pc_ras.sv
// ---------------------------------------------------------------------------
// pc_ras
// Fetch-stage program counter with relative branches and a hardware
// return-address stack for call/return.
//   clk       : clock, all state updates on rising edge
//   rst       : synchronous active-high reset (highest priority)
//   stall     : freeze PC, stack and flags this cycle
//   op        : next-PC operation (pc_pkg::pc_op_e)
//   d         : jump target (JMP/CALL) or signed offset (REL)
//   o         : current PC, registered
//   depth     : valid return-address entries
//   ras_full  : depth == RAS_DEPTH
//   ras_empty : depth == 0
//   err_ovf   : sticky, CALL attempted while full
//   err_unf   : sticky, RET attempted while empty
// ---------------------------------------------------------------------------
module pc_ras
   import pc_pkg::*;
#(
   parameter  int               WIDTH     = 16,
   parameter  int               RAS_DEPTH = 8,
   parameter  logic [WIDTH-1:0] RESET_VEC = '0,
   localparam int               DEPTH_W   = $clog2(RAS_DEPTH + 1)
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               stall,
   input  logic [PC_OP_W-1:0] op,
   input  logic [WIDTH-1:0]   d,
   output logic [WIDTH-1:0]   o,
   output logic [DEPTH_W-1:0] depth,
   output logic               ras_full,
   output logic               ras_empty,
   output logic               err_ovf,
   output logic               err_unf
);

   logic [WIDTH-1:0] o_q, o_d;
   logic             ovf_q, ovf_d;
   logic             unf_q, unf_d;
   logic             push, pop;
   logic [WIDTH-1:0] ras_top;
   logic [WIDTH-1:0] o_inc;

   // Shared by INC, the CALL return address and the RET fall-through;
   // wraps modulo 2^WIDTH.
   assign o_inc = o_q + WIDTH'(1);

   pc_ras_stack #(
      .WIDTH     (WIDTH),
      .RAS_DEPTH (RAS_DEPTH)
   ) u_stack (
      .clk   (clk),
      .rst   (rst),
      .push  (push),
      .pop   (pop),
      .din   (o_inc),
      .top   (ras_top),
      .depth (depth),
      .full  (ras_full),
      .empty (ras_empty)
   );

   always_comb begin
      o_d   = o_q;
      ovf_d = ovf_q;
      unf_d = unf_q;
      push  = 1'b0;
      pop   = 1'b0;
      if (!stall) begin
         case (pc_op_e'(op))
            PC_INC:  o_d = o_inc;
            PC_JMP:  o_d = d;
            // Unsigned add of a two's-complement offset is the signed add.
            PC_REL:  o_d = o_q + d;
            PC_CALL: begin
               push = 1'b1;   // stack drops it when full
               o_d  = d;
               if (ras_full) begin
                  ovf_d = 1'b1;
               end
            end
            PC_RET: begin
               if (ras_empty) begin
                  o_d   = o_inc;  // fall through on underflow
                  unf_d = 1'b1;
               end else begin
                  pop = 1'b1;
                  o_d = ras_top;
               end
            end
            default: ;  // PC_HOLD and reserved encodings
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         o_q   <= RESET_VEC;
         ovf_q <= 1'b0;
         unf_q <= 1'b0;
      end else begin
         o_q   <= o_d;
         ovf_q <= ovf_d;
         unf_q <= unf_d;
      end
   end

   assign o       = o_q;
   assign err_ovf = ovf_q;
   assign err_unf = unf_q;

endmodule : pc_ras

// File: tb/tb_pc_ras.sv
// ---------------------------------------------------------------------------
// tb_pc_ras
// Directed self-checking bench for pc_ras (WIDTH=16, RAS_DEPTH=8,
// RESET_VEC=0). Inputs change 1 time unit after a rising edge and outputs
// are sampled 1 time unit after the following edge.
// ---------------------------------------------------------------------------
module tb_pc_ras;
   import pc_pkg::*;

   localparam int WIDTH     = 16;
   localparam int RAS_DEPTH = 8;
   localparam int DEPTH_W   = $clog2(RAS_DEPTH + 1);

   logic               clk = 1'b0;
   logic               rst;
   logic               stall;
   logic [PC_OP_W-1:0] op;
   logic [WIDTH-1:0]   d;
   logic [WIDTH-1:0]   o;
   logic [DEPTH_W-1:0] depth;
   logic               ras_full, ras_empty, err_ovf, err_unf;

   int n_checks = 0;
   int n_fail   = 0;

   pc_ras #(
      .WIDTH     (WIDTH),
      .RAS_DEPTH (RAS_DEPTH),
      .RESET_VEC (16'h0000)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .stall     (stall),
      .op        (op),
      .d         (d),
      .o         (o),
      .depth     (depth),
      .ras_full  (ras_full),
      .ras_empty (ras_empty),
      .err_ovf   (err_ovf),
      .err_unf   (err_unf)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs,
                        input logic [31:0] exp);
      n_checks++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Apply one cycle of inputs, then sample just after the edge.
   task automatic step(input logic r, input logic s, input pc_op_e o_op,
                       input logic [WIDTH-1:0] dv);
      rst   = r;
      stall = s;
      op    = o_op;
      d     = dv;
      @(posedge clk);
      #1;
   endtask

   task automatic step_raw(input logic [PC_OP_W-1:0] raw_op);
      rst   = 1'b0;
      stall = 1'b0;
      op    = raw_op;
      d     = 16'hABCD;
      @(posedge clk);
      #1;
   endtask

   task automatic check_status(input string tag, input logic [WIDTH-1:0] e_o,
                               input int e_depth, input logic e_ovf,
                               input logic e_unf);
      check({tag, ".o"},     32'(o),         32'(e_o));
      check({tag, ".depth"}, 32'(depth),     32'(e_depth));
      check({tag, ".full"},  32'(ras_full),  32'(e_depth == RAS_DEPTH));
      check({tag, ".empty"}, 32'(ras_empty), 32'(e_depth == 0));
      check({tag, ".ovf"},   32'(err_ovf),   32'(e_ovf));
      check({tag, ".unf"},   32'(err_unf),   32'(e_unf));
   endtask

   initial begin
      rst = 1'b1; stall = 1'b0; op = PC_HOLD; d = '0;

      // Reset for two cycles, then increment.
      step(1'b1, 1'b0, PC_INC, 16'h0000);
      step(1'b1, 1'b0, PC_INC, 16'h0000);
      check_status("reset", 16'h0000, 0, 1'b0, 1'b0);
      step(1'b0, 1'b0, PC_INC, 16'h0000);  check_status("inc1", 16'h0001, 0, 1'b0, 1'b0);
      step(1'b0, 1'b0, PC_INC, 16'h0000);  check_status("inc2", 16'h0002, 0, 1'b0, 1'b0);
      step(1'b0, 1'b0, PC_INC, 16'h0000);  check_status("inc3", 16'h0003, 0, 1'b0, 1'b0);
      step(1'b0, 1'b0, PC_HOLD, 16'h7777); check("hold.o", 32'(o), 32'h0003);

      // Jump, backward relative branch, wrap.
      step(1'b0, 1'b0, PC_JMP, 16'h0010);  check("jmp.o", 32'(o), 32'h0010);
      step(1'b0, 1'b0, PC_REL, 16'hFFFC);  check("rel_neg.o", 32'(o), 32'h000C);
      step(1'b0, 1'b0, PC_REL, 16'h0004);  check("rel_pos.o", 32'(o), 32'h0010);
      step(1'b0, 1'b0, PC_JMP, 16'hFFFF);  check("jmp_top.o", 32'(o), 32'hFFFF);
      step(1'b0, 1'b0, PC_INC, 16'h0000);  check("inc_wrap.o", 32'(o), 32'h0000);

      // Nested call/return.
      step(1'b0, 1'b0, PC_JMP, 16'h0005);  check("jmp5.o", 32'(o), 32'h0005);
      step(1'b0, 1'b0, PC_CALL, 16'h0100); check_status("call1", 16'h0100, 1, 1'b0, 1'b0);
      step(1'b0, 1'b0, PC_CALL, 16'h0200); check_status("call2", 16'h0200, 2, 1'b0, 1'b0);
      step(1'b0, 1'b0, PC_RET, 16'h0000);  check_status("ret2", 16'h0101, 1, 1'b0, 1'b0);
      step(1'b0, 1'b0, PC_RET, 16'h0000);  check_status("ret1", 16'h0006, 0, 1'b0, 1'b0);

      // Back-to-back CALL then RET.
      step(1'b0, 1'b0, PC_CALL, 16'h0050); check_status("b2b_call", 16'h0050, 1, 1'b0, 1'b0);
      step(1'b0, 1'b0, PC_RET, 16'h0000);  check_status("b2b_ret", 16'h0007, 0, 1'b0, 1'b0);

      // Fill the stack: 1st call at 0x0007 pushes 0x0008, call i (i>=1)
      // at 0x0400+i-1 pushes 0x0400+i, so the top is 0x0407.
      for (int i = 0; i < RAS_DEPTH; i++) begin
         step(1'b0, 1'b0, PC_CALL, 16'h0400 + 16'(i));
         check("fill.depth", 32'(depth), 32'(i + 1));
      end
      check_status("full", 16'h0407, 8, 1'b0, 1'b0);
      step(1'b0, 1'b0, PC_CALL, 16'h0300); check_status("ovf_call", 16'h0300, 8, 1'b1, 1'b0);
      step(1'b0, 1'b0, PC_RET, 16'h0000);  check_status("ovf_ret", 16'h0407, 7, 1'b1, 1'b0);
      step(1'b0, 1'b0, PC_RET, 16'h0000);  check_status("ovf_ret2", 16'h0406, 6, 1'b1, 1'b0);

      // Stall freezes everything whatever the op.
      step(1'b0, 1'b1, PC_CALL, 16'h1234); check_status("stall_call", 16'h0406, 6, 1'b1, 1'b0);
      step(1'b0, 1'b1, PC_RET, 16'h0000);  check_status("stall_ret", 16'h0406, 6, 1'b1, 1'b0);
      step(1'b0, 1'b1, PC_INC, 16'h0000);  check_status("stall_inc", 16'h0406, 6, 1'b1, 1'b0);

      // Reserved encodings hold.
      step_raw(3'd6); check_status("rsv6", 16'h0406, 6, 1'b1, 1'b0);
      step_raw(3'd7); check_status("rsv7", 16'h0406, 6, 1'b1, 1'b0);

      // Reset wins over a CALL on the same edge.
      step(1'b1, 1'b0, PC_CALL, 16'h0999); check_status("rst_call", 16'h0000, 0, 1'b0, 1'b0);

      // Underflow from empty falls through.
      step(1'b0, 1'b0, PC_JMP, 16'h0040);  check("jmp40.o", 32'(o), 32'h0040);
      step(1'b0, 1'b0, PC_RET, 16'h0000);  check_status("unf_ret", 16'h0041, 0, 1'b0, 1'b1);

      // Overflow again: 9 calls to 0x0500.. leave o at 0x0508.
      for (int i = 0; i < RAS_DEPTH + 1; i++) begin
         step(1'b0, 1'b0, PC_CALL, 16'h0500 + 16'(i));
      end
      check_status("ovf2", 16'h0508, 8, 1'b1, 1'b1);

      // Both flags persist across 10 INCs.
      for (int i = 0; i < 10; i++) begin
         step(1'b0, 1'b0, PC_INC, 16'h0000);
         check("sticky.ovf", 32'(err_ovf), 32'h1);
         check("sticky.unf", 32'(err_unf), 32'h1);
      end
      check_status("after_inc", 16'h0512, 8, 1'b1, 1'b1);

      // Reset during a stall still takes effect.
      step(1'b1, 1'b1, PC_CALL, 16'h0777); check_status("rst_stall", 16'h0000, 0, 1'b0, 1'b0);
      step(1'b0, 1'b0, PC_RET, 16'h0000);  check_status("post_rst_ret", 16'h0001, 0, 1'b0, 1'b1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule : tb_pc_ras
